mem_arbiter: RTL

Shares the single system memory write/read port between the debug write interface (UART or SPI), the cpu16 instruction fetch port and the cpu16 data port. Decodes the address map (SRAM, VRAM, control), owns the control register that holds the CPU in reset, and generates the per-port `rdy` handshakes that cpu16 expects. Sits between cpu16/debug interface and `sram`/`vga40x30x2`.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter for the debug writer, cpu16 fetch port and cpu16 data port.
// Decodes SRAM / VRAM / control regions and owns the cpu_reset control bit.
module mem_arbiter #(
  parameter int          SRAM_AW = 8,
  parameter logic [15:0] FILL    = 16'hEEEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dbg_we,
  input  logic [15:0] dbg_waddr,
  input  logic [15:0] dbg_wdata,
  input  logic [15:0] ins_rd_addr,
  input  logic        ins_rd_req,
  output logic        ins_rd_rdy,
  output logic [15:0] ins_rd_data,
  input  logic [15:0] dat_rw_addr,
  input  logic [15:0] dat_wr_data,
  input  logic        dat_rd_req,
  input  logic        dat_wr_req,
  output logic        dat_rd_rdy,
  output logic        dat_wr_rdy,
  output logic [15:0] dat_rd_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        sram_re,
  output logic        sram_we,
  output logic        vram_we,
  input  logic [15:0] sram_rdata,
  output logic        cpu_reset
);

  typedef enum logic [1:0] {SRC_NONE, SRC_D, SRC_I, SRC_C} src_t;
  typedef enum logic {LAST_C, LAST_I} last_t;

  src_t        src;
  last_t       last;
  logic        el_i, el_c;
  logic        sel_we;
  logic        sram_hit, vram_hit, ctrl_hit;
  logic        ins_out, dat_out, dat_wr_q;
  logic        rd_sram_q;
  logic [15:0] rd_alt_q;
  logic [15:0] rd_value;
  logic [15:0] ins_hold, dat_hold;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    el_i      = ins_rd_req & ~ins_out & ~cpu_reset & ~reset;
    el_c      = (dat_rd_req | dat_wr_req) & ~dat_out & ~cpu_reset & ~reset;
    src       = SRC_NONE;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    sel_we    = 1'b0;

    if (reset)             src = SRC_NONE;
    else if (dbg_we)       src = SRC_D;
    else if (el_i && el_c) src = (last == LAST_I) ? SRC_C : SRC_I;
    else if (el_i)         src = SRC_I;
    else if (el_c)         src = SRC_C;

    unique case (src)
      SRC_D: begin
        mem_addr  = dbg_waddr;
        mem_wdata = dbg_wdata;
        sel_we    = 1'b1;
      end
      SRC_I: mem_addr = ins_rd_addr;
      SRC_C: begin
        mem_addr  = dat_rw_addr;
        mem_wdata = dat_wr_data;
        // A simultaneous read+write request is served as a write.
        sel_we    = dat_wr_req;
      end
      default: ;
    endcase

    // Region-0 addresses beyond the SRAM depth fall through to unmapped.
    sram_hit = (mem_addr >> SRAM_AW) == 16'h0000;
    vram_hit = mem_addr[15:12] == 4'h8;
    ctrl_hit = mem_addr[15:12] == 4'hF;

    sram_re = (src != SRC_NONE) & ~sel_we & sram_hit;
    sram_we = sel_we & sram_hit;
    vram_we = sel_we & vram_hit;
  end

  assign rd_value    = rd_sram_q ? sram_rdata : rd_alt_q;
  assign ins_rd_rdy  = ins_out & ~reset;
  assign dat_rd_rdy  = dat_out & ~dat_wr_q & ~reset;
  assign dat_wr_rdy  = dat_out & dat_wr_q & ~reset;
  assign ins_rd_data = ins_rd_rdy ? rd_value : ins_hold;
  assign dat_rd_data = dat_rd_rdy ? rd_value : dat_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= LAST_C;
      ins_out   <= 1'b0;
      dat_out   <= 1'b0;
      dat_wr_q  <= 1'b0;
      rd_sram_q <= 1'b0;
      rd_alt_q  <= 16'h0000;
      cpu_reset <= 1'b0;
      ins_hold  <= 16'h0000;
      dat_hold  <= 16'h0000;
    end else begin
      // Outstanding flags live exactly one cycle: the rdy cycle.
      ins_out   <= (src == SRC_I);
      dat_out   <= (src == SRC_C);
      dat_wr_q  <= (src == SRC_C) && dat_wr_req;
      rd_sram_q <= sram_hit;
      rd_alt_q  <= ctrl_hit ? {15'b0, cpu_reset} : FILL;
      if (src == SRC_I)                    last      <= LAST_I;
      else if (src == SRC_C)               last      <= LAST_C;
      if (sel_we && ctrl_hit)              cpu_reset <= mem_wdata[0];
      if (ins_rd_rdy)                      ins_hold  <= rd_value;
      if (dat_rd_rdy)                      dat_hold  <= rd_value;
    end
  end

endmodule
